usb_txn_ctrl: RTL and testbench
===============================

# usb_txn_ctrl

Device-side transaction controller that sequences the USB RX, USB TX and data buffer for one bulk endpoint. It watches completed receive packets, decides the response (DATA0/DATA1, ACK, NAK or STALL), and commands the transmitter. It tracks the IN and OUT data toggles and pulses the buffer clear when received data must be discarded. It sits beside the AHB-Lite slave, which loads TX data, consumes RX data and reads its status.

## Interface
- TIMEOUT, 64: clk cycles allowed in any wait state before abort (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_packet  in  3  PID of the packet being received: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
- rx_transfer_active  in  1  high while the receiver is inside a packet
- rx_error  in  1  receiver error flag for the current packet
- tx_transfer_active  in  1  high while the transmitter is sending
- tx_error  in  1  transmitter error flag
- tx_data_loaded  in  1  one-cycle pulse: software finished loading an IN payload
- rx_ack  in  1  one-cycle pulse: software consumed OUT payload
- stall_en  in  1  level: endpoint halted
- tx_packet  out  3  transmit command, non-zero for exactly one cycle: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL
- clear  out  1  one-cycle pulse that flushes the data buffer
- rx_data_avail  out  1  OUT payload accepted and held in the buffer
- tx_ready  out  1  IN payload armed
- in_toggle, out_toggle  out  1 each  expected data toggle per direction
- txn_error  out  1  sticky error, cleared only by rst or rx_ack
- state  out  3  current FSM state, for debug

## Operation
- EOP event: rx_transfer_active was 1 in the previous cycle and is 0 now. The decision uses rx_packet and rx_error in the EOP cycle. TX completion follows the same rule on tx_transfer_active.
- States: IDLE, OUT_DATA, IN_TX, IN_WAIT_ACK, HS_SEND, HS_WAIT.
- IDLE, EOP with error: set txn_error and stay in IDLE. EOP with a PID other than OUT or IN: ignore it.
- IDLE, EOP with OUT: go to OUT_DATA.
- IDLE, EOP with IN:
  - stall_en=1: send STALL through HS_SEND.
  - else tx_ready=1: issue DATA(in_toggle) and go to IN_TX.
  - else: send NAK through HS_SEND.
- OUT_DATA, EOP with DATA0 or DATA1 (toggle bit t = PID==DATA1):
  - rx_error: pulse clear, set txn_error, return to IDLE with no handshake.
  - else stall_en: pulse clear, send STALL.
  - else rx_data_avail=1: pulse clear, send NAK.
  - else t==out_toggle: send ACK, set rx_data_avail, invert out_toggle.
  - else (retransmission): pulse clear, send ACK, leave out_toggle unchanged.
- OUT_DATA, EOP with any other PID: pulse clear, return to IDLE.
- HS_SEND: drive tx_packet for one cycle, then go to HS_WAIT.
- HS_WAIT: wait for tx_transfer_active to rise and then fall, then return to IDLE. If tx_error is seen during the wait, set txn_error.
- IN_TX: wait for the TX completion, then go to IN_WAIT_ACK. If tx_error is seen, set txn_error.
- IN_WAIT_ACK, EOP with ACK and no error: invert in_toggle, clear tx_ready, return to IDLE.
- IN_WAIT_ACK, any other EOP: set txn_error, clear tx_ready, pulse clear, return to IDLE. in_toggle is unchanged and software must reload the payload.
- tx_data_loaded sets tx_ready. rx_ack clears rx_data_avail and txn_error.
- Timeout: the counter resets on entry to OUT_DATA, IN_TX, IN_WAIT_ACK and HS_WAIT. When it reaches TIMEOUT: set txn_error, pulse clear (except in HS_WAIT), clear tx_ready if in an IN state, return to IDLE.
- Counter width is $clog2(TIMEOUT+1) and it saturates.

## Timing
- Reset values: state=IDLE, tx_packet=0, clear=0, rx_data_avail=0, tx_ready=0, in_toggle=0, out_toggle=0, txn_error=0, counter=0.
- Every output is registered.
- Latency: for an EOP in cycle N, tx_packet is non-zero in cycle N+1 on the direct DATA path, or in cycle N+2 via HS_SEND.
- Latency: any clear pulse caused by an EOP in cycle N occurs in cycle N+1.
- Simultaneous events resolve against registered values. tx_data_loaded in the same cycle as an IN EOP still sees tx_ready=0, so the response is NAK.
- Simultaneous rx_ack in the same cycle as a DATA EOP still sees rx_data_avail=1, so the response is NAK.
- The rx_ack clear and an OUT-data set of rx_data_avail in the same cycle: the set wins.
- rst mid-transaction: all state reaches reset values at the next edge, with no clear pulse and no tx_packet.

## Test plan
- OUT token then DATA0, clean, after reset -> tx_packet=3 (ACK) at EOP+2; rx_data_avail=1; out_toggle=1; no clear pulse.
- Second OUT+DATA0 with rx_data_avail=1 (retransmission path not taken) -> clear pulse at EOP+1; NAK; out_toggle stays 1. After rx_ack, OUT+DATA0 -> ACK plus clear; out_toggle stays 1.
- tx_data_loaded, then IN -> tx_packet=1 (DATA0) at EOP+1. After TX completes, host sends ACK -> in_toggle=1, tx_ready=0.
- IN with tx_ready=0 -> NAK. IN with stall_en=1 and tx_ready=1 -> STALL; tx_ready stays 1.
- OUT token with no DATA packet for TIMEOUT=64 cycles -> txn_error=1; clear pulse; state=IDLE at cycle 64. rx_ack -> txn_error=0.
- rst asserted during IN_WAIT_ACK -> next cycle: all outputs at reset values, tx_packet=0, clear=0.

Source files
------------

// File: rtl/usb_txn_ctrl_if.sv
// Bus bundle between the USB RX/TX/buffer datapath and the bulk-endpoint
// transaction controller.
interface usb_txn_ctrl_if;
    logic [2:0] rx_packet;
    logic       rx_transfer_active;
    logic       rx_error;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       tx_data_loaded;
    logic       rx_ack;
    logic       stall_en;
    logic [2:0] tx_packet;
    logic       clear;
    logic       rx_data_avail;
    logic       tx_ready;
    logic       in_toggle;
    logic       out_toggle;
    logic       txn_error;
    logic [2:0] state;

    modport master (
        output rx_packet, rx_transfer_active, rx_error, tx_transfer_active,
               tx_error, tx_data_loaded, rx_ack, stall_en,
        input  tx_packet, clear, rx_data_avail, tx_ready, in_toggle,
               out_toggle, txn_error, state
    );

    modport slave (
        input  rx_packet, rx_transfer_active, rx_error, tx_transfer_active,
               tx_error, tx_data_loaded, rx_ack, stall_en,
        output tx_packet, clear, rx_data_avail, tx_ready, in_toggle,
               out_toggle, txn_error, state
    );
endinterface

// File: rtl/usb_txn_ctrl.sv
// Bulk-endpoint transaction controller: decodes received tokens/data, picks
// the handshake, drives the transmitter and tracks IN/OUT data toggles.
module usb_txn_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    usb_txn_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] RX_OUT   = 3'd1;
    localparam logic [2:0] RX_IN    = 3'd2;
    localparam logic [2:0] RX_DATA0 = 3'd3;
    localparam logic [2:0] RX_DATA1 = 3'd4;
    localparam logic [2:0] RX_ACK   = 3'd5;

    localparam logic [2:0] TX_DATA0 = 3'd1;
    localparam logic [2:0] TX_DATA1 = 3'd2;
    localparam logic [2:0] TX_ACK   = 3'd3;
    localparam logic [2:0] TX_NAK   = 3'd4;
    localparam logic [2:0] TX_STALL = 3'd5;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        OUT_DATA    = 3'd1,
        IN_TX       = 3'd2,
        IN_WAIT_ACK = 3'd3,
        HS_SEND     = 3'd4,
        HS_WAIT     = 3'd5
    } state_t;

    state_t          r_state, w_state;
    logic [2:0]      r_tx_packet, w_tx_packet;
    logic [2:0]      r_hs_pid, w_hs_pid;
    logic            r_clear, w_clear;
    logic            r_rx_avail, w_rx_avail;
    logic            r_tx_ready, w_tx_ready;
    logic            r_in_tog, w_in_tog;
    logic            r_out_tog, w_out_tog;
    logic            r_err, w_err;
    logic [CW-1:0]   r_cnt, w_cnt, w_cnt_inc;
    logic            r_rx_act_d, r_tx_act_d;
    logic            w_rx_eop, w_tx_eop, w_tmo, w_is_data, w_tog_bit;

    assign w_rx_eop  = r_rx_act_d & ~bus.rx_transfer_active;
    assign w_tx_eop  = r_tx_act_d & ~bus.tx_transfer_active;
    assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);
    assign w_tmo     = (w_cnt_inc == CW'(TIMEOUT));
    assign w_is_data = (bus.rx_packet == RX_DATA0) || (bus.rx_packet == RX_DATA1);
    assign w_tog_bit = (bus.rx_packet == RX_DATA1);

    always_comb begin
        w_state     = r_state;
        w_tx_packet = '0;
        w_hs_pid    = r_hs_pid;
        w_clear     = 1'b0;
        w_rx_avail  = r_rx_avail;
        w_tx_ready  = r_tx_ready;
        w_in_tog    = r_in_tog;
        w_out_tog   = r_out_tog;
        w_err       = r_err;
        w_cnt       = '0;

        // Software strobes first so FSM actions in the same cycle take priority.
        if (bus.tx_data_loaded) w_tx_ready = 1'b1;
        if (bus.rx_ack) begin
            w_rx_avail = 1'b0;
            w_err      = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_rx_eop) begin
                    if (bus.rx_error) begin
                        w_err = 1'b1;
                    end else if (bus.rx_packet == RX_OUT) begin
                        w_state = OUT_DATA;
                    end else if (bus.rx_packet == RX_IN) begin
                        if (bus.stall_en) begin
                            w_hs_pid = TX_STALL;
                            w_state  = HS_SEND;
                        end else if (r_tx_ready) begin
                            w_tx_packet = r_in_tog ? TX_DATA1 : TX_DATA0;
                            w_state     = IN_TX;
                        end else begin
                            w_hs_pid = TX_NAK;
                            w_state  = HS_SEND;
                        end
                    end
                end
            end
            OUT_DATA: begin
                w_cnt = w_cnt_inc;
                if (w_rx_eop) begin
                    w_state = IDLE;
                    if (!w_is_data) begin
                        w_clear = 1'b1;
                    end else if (bus.rx_error) begin
                        w_clear = 1'b1;
                        w_err   = 1'b1;
                    end else if (bus.stall_en) begin
                        w_clear  = 1'b1;
                        w_hs_pid = TX_STALL;
                        w_state  = HS_SEND;
                    end else if (r_rx_avail) begin
                        w_clear  = 1'b1;
                        w_hs_pid = TX_NAK;
                        w_state  = HS_SEND;
                    end else if (w_tog_bit == r_out_tog) begin
                        w_hs_pid   = TX_ACK;
                        w_state    = HS_SEND;
                        w_rx_avail = 1'b1;
                        w_out_tog  = ~r_out_tog;
                    end else begin
                        w_clear  = 1'b1;
                        w_hs_pid = TX_ACK;
                        w_state  = HS_SEND;
                    end
                end else if (w_tmo) begin
                    w_err   = 1'b1;
                    w_clear = 1'b1;
                    w_state = IDLE;
                end
            end
            IN_TX: begin
                w_cnt = w_cnt_inc;
                if (bus.tx_error) w_err = 1'b1;
                if (w_tx_eop) begin
                    w_state = IN_WAIT_ACK;
                    w_cnt   = '0;
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_clear    = 1'b1;
                    w_tx_ready = 1'b0;
                    w_state    = IDLE;
                end
            end
            IN_WAIT_ACK: begin
                w_cnt = w_cnt_inc;
                if (w_rx_eop) begin
                    w_state    = IDLE;
                    w_tx_ready = 1'b0;
                    if (bus.rx_packet == RX_ACK && !bus.rx_error) begin
                        w_in_tog = ~r_in_tog;
                    end else begin
                        w_err   = 1'b1;
                        w_clear = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_clear    = 1'b1;
                    w_tx_ready = 1'b0;
                    w_state    = IDLE;
                end
            end
            HS_SEND: begin
                w_tx_packet = r_hs_pid;
                w_state     = HS_WAIT;
            end
            HS_WAIT: begin
                w_cnt = w_cnt_inc;
                if (bus.tx_error) w_err = 1'b1;
                if (w_tx_eop) begin
                    w_state = IDLE;
                end else if (w_tmo) begin
                    w_err   = 1'b1;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx_packet <= '0;
            r_hs_pid    <= '0;
            r_clear     <= 1'b0;
            r_rx_avail  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_in_tog    <= 1'b0;
            r_out_tog   <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_rx_act_d  <= 1'b0;
            r_tx_act_d  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_tx_packet <= w_tx_packet;
            r_hs_pid    <= w_hs_pid;
            r_clear     <= w_clear;
            r_rx_avail  <= w_rx_avail;
            r_tx_ready  <= w_tx_ready;
            r_in_tog    <= w_in_tog;
            r_out_tog   <= w_out_tog;
            r_err       <= w_err;
            r_cnt       <= w_cnt;
            r_rx_act_d  <= bus.rx_transfer_active;
            r_tx_act_d  <= bus.tx_transfer_active;
        end
    end

    assign bus.tx_packet     = r_tx_packet;
    assign bus.clear         = r_clear;
    assign bus.rx_data_avail = r_rx_avail;
    assign bus.tx_ready      = r_tx_ready;
    assign bus.in_toggle     = r_in_tog;
    assign bus.out_toggle    = r_out_tog;
    assign bus.txn_error     = r_err;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboard bench for usb_txn_ctrl: handshake/clear expectations are queued
// with their latency when a packet is driven and matched when the DUT emits them.
module tb_usb_txn_ctrl;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [2:0] pid;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    usb_txn_ctrl_if bus();

    usb_txn_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_eop = 0;
    exp_t q_tx[$];
    int   q_clr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Every non-zero tx_packet and every clear pulse must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   l;
        if (bus.tx_packet != 3'd0) begin
            if (q_tx.size() == 0) begin
                check("tx_unexpected", 32'(bus.tx_packet), 32'd0);
            end else begin
                e = q_tx.pop_front();
                check("tx_pid", 32'(bus.tx_packet), 32'(e.pid));
                check("tx_lat", cyc - last_eop, e.lat);
            end
        end
        if (bus.clear) begin
            if (q_clr.size() == 0) begin
                check("clr_unexpected", 32'd1, 32'd0);
            end else begin
                l = q_clr.pop_front();
                check("clr_lat", cyc - last_eop, l);
            end
        end
    end

    task automatic send_pkt(input logic [2:0] pid, input logic err, input logic [1:0] side,
                            input logic [2:0] exp_tx, input int tx_lat, input int clr_lat);
        exp_t e;
        @(negedge clk);
        if (exp_tx != 3'd0) begin
            e.pid = exp_tx;
            e.lat = tx_lat;
            q_tx.push_back(e);
        end
        if (clr_lat > 0) q_clr.push_back(clr_lat);
        bus.rx_packet          = pid;
        bus.rx_error           = err;
        bus.rx_transfer_active = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_transfer_active = 1'b0;
        bus.tx_data_loaded     = side[0];
        bus.rx_ack             = side[1];
        last_eop               = cyc;
        @(negedge clk);
        bus.rx_packet      = 3'd0;
        bus.rx_error       = 1'b0;
        bus.tx_data_loaded = 1'b0;
        bus.rx_ack         = 1'b0;
    endtask

    task automatic tx_busy();
        @(negedge clk);
        bus.tx_transfer_active = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_transfer_active = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic pulse_loaded();
        @(negedge clk);
        bus.tx_data_loaded = 1'b1;
        @(negedge clk);
        bus.tx_data_loaded = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_txpkt"}, 32'(bus.tx_packet), 32'd0);
        check({tag, "_clear"}, 32'(bus.clear), 32'd0);
        check({tag, "_avail"}, 32'(bus.rx_data_avail), 32'd0);
        check({tag, "_txrdy"}, 32'(bus.tx_ready), 32'd0);
        check({tag, "_intog"}, 32'(bus.in_toggle), 32'd0);
        check({tag, "_outtog"}, 32'(bus.out_toggle), 32'd0);
        check({tag, "_err"}, 32'(bus.txn_error), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_packet = 3'd0;
        bus.rx_transfer_active = 1'b0;
        bus.rx_error = 1'b0;
        bus.tx_transfer_active = 1'b0;
        bus.tx_error = 1'b0;
        bus.tx_data_loaded = 1'b0;
        bus.rx_ack = 1'b0;
        bus.stall_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        // Clean OUT + DATA0: ACK two cycles after EOP, toggle flips.
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd3, 1'b0, 2'b00, 3'd3, 2, 0);
        tx_busy();
        check("out1_avail", 32'(bus.rx_data_avail), 32'd1);
        check("out1_tog", 32'(bus.out_toggle), 32'd1);
        check("out1_state", 32'(bus.state), 32'd0);

        // Buffer still full: NAK with clear.
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd3, 1'b0, 2'b00, 3'd4, 2, 1);
        tx_busy();
        check("out2_tog", 32'(bus.out_toggle), 32'd1);
        check("out2_avail", 32'(bus.rx_data_avail), 32'd1);

        // Retransmitted DATA0 after consume: ACK + clear, no toggle change.
        pulse_ack();
        check("ack_avail", 32'(bus.rx_data_avail), 32'd0);
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd3, 1'b0, 2'b00, 3'd3, 2, 1);
        tx_busy();
        check("retx_tog", 32'(bus.out_toggle), 32'd1);
        check("retx_avail", 32'(bus.rx_data_avail), 32'd0);

        // DATA1 matches: accepted, toggle back to 0.
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd4, 1'b0, 2'b00, 3'd3, 2, 0);
        tx_busy();
        check("out3_tog", 32'(bus.out_toggle), 32'd0);
        check("out3_avail", 32'(bus.rx_data_avail), 32'd1);
        pulse_ack();

        // IN with armed payload: DATA0 direct, then host ACK.
        pulse_loaded();
        check("load_rdy", 32'(bus.tx_ready), 32'd1);
        send_pkt(3'd2, 1'b0, 2'b00, 3'd1, 1, 0);
        check("in_tx_state", 32'(bus.state), 32'd2);
        tx_busy();
        check("in_wait_state", 32'(bus.state), 32'd3);
        send_pkt(3'd5, 1'b0, 2'b00, 3'd0, 0, 0);
        check("in_ack_tog", 32'(bus.in_toggle), 32'd1);
        check("in_ack_rdy", 32'(bus.tx_ready), 32'd0);
        check("in_ack_state", 32'(bus.state), 32'd0);

        // IN with nothing armed: NAK.
        send_pkt(3'd2, 1'b0, 2'b00, 3'd4, 2, 0);
        tx_busy();

        // Corrupted token in IDLE: error only, no response.
        send_pkt(3'd2, 1'b1, 2'b00, 3'd0, 0, 0);
        repeat (2) @(negedge clk);
        check("idle_err", 32'(bus.txn_error), 32'd1);
        check("idle_err_state", 32'(bus.state), 32'd0);
        pulse_ack();
        check("idle_err_clr", 32'(bus.txn_error), 32'd0);

        // Halted endpoint: STALL, payload stays armed.
        pulse_loaded();
        bus.stall_en = 1'b1;
        send_pkt(3'd2, 1'b0, 2'b00, 3'd5, 2, 0);
        tx_busy();
        bus.stall_en = 1'b0;
        check("stall_rdy", 32'(bus.tx_ready), 32'd1);

        // DATA1 sent, host answers NAK: error + clear, toggle kept.
        send_pkt(3'd2, 1'b0, 2'b00, 3'd2, 1, 0);
        tx_busy();
        send_pkt(3'd6, 1'b0, 2'b00, 3'd0, 0, 1);
        check("badack_err", 32'(bus.txn_error), 32'd1);
        check("badack_rdy", 32'(bus.tx_ready), 32'd0);
        check("badack_tog", 32'(bus.in_toggle), 32'd1);
        pulse_ack();
        check("badack_errclr", 32'(bus.txn_error), 32'd0);

        // Load in the same cycle as IN EOP: still NAK, armed afterwards.
        send_pkt(3'd2, 1'b0, 2'b01, 3'd4, 2, 0);
        tx_busy();
        check("simload_rdy", 32'(bus.tx_ready), 32'd1);

        // OUT token with no data: abort after TIMEOUT cycles in OUT_DATA.
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, TIMEOUT + 1);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_before", 32'(bus.state), 32'd1);
        check("tmo_before_err", 32'(bus.txn_error), 32'd0);
        @(negedge clk);
        check("tmo_state", 32'(bus.state), 32'd0);
        check("tmo_err", 32'(bus.txn_error), 32'd1);
        pulse_ack();
        check("tmo_errclr", 32'(bus.txn_error), 32'd0);

        // Fill buffer, then rx_ack coinciding with DATA EOP: NAK decided on full buffer.
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd3, 1'b0, 2'b00, 3'd3, 2, 0);
        tx_busy();
        check("fill_avail", 32'(bus.rx_data_avail), 32'd1);
        send_pkt(3'd1, 1'b0, 2'b00, 3'd0, 0, 0);
        send_pkt(3'd4, 1'b0, 2'b10, 3'd4, 2, 1);
        tx_busy();
        check("simack_avail", 32'(bus.rx_data_avail), 32'd0);
        check("simack_tog", 32'(bus.out_toggle), 32'd1);

        // Reset while waiting for the host ACK.
        send_pkt(3'd2, 1'b0, 2'b00, 3'd2, 1, 0);
        tx_busy();
        check("prerst_state", 32'(bus.state), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;

        repeat (5) @(negedge clk);
        check("q_tx_left", q_tx.size(), 32'd0);
        check("q_clr_left", q_clr.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
